// File: rtl/en_arbiter_if.sv
// Requester-side bus of the enable-path arbiter: global enable, per-requester
// request/data, and the registered grant/busy plus the forwarded enable bit.
interface en_arbiter_if #(
    parameter int N_REQ = 4
);
    logic             ena;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] din;
    logic [N_REQ-1:0] gnt;
    logic             en_out;
    logic             busy;

    modport master (
        output ena, req, din,
        input  gnt, en_out, busy
    );

    modport slave (
        input  ena, req, din,
        output gnt, en_out, busy
    );
endinterface

// File: rtl/en_arbiter.sv
// Round-robin arbiter sharing the en_out path between N_REQ requesters.
// Optional hold-timeout forced release is compiled in with EN_ARB_TIMEOUT_EN.
module en_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    en_arbiter_if.slave bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // First requester at or after start_v in wrap-around order; MSB flags a hit.
    function automatic logic [PTR_W:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                               input logic [PTR_W-1:0] start_v);
        logic [PTR_W:0]   cand_v;
        logic             found_v;
        logic [PTR_W-1:0] idx_v;
        found_v = 1'b0;
        idx_v   = {PTR_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            cand_v = {1'b0, start_v} + (PTR_W+1)'(i);
            if (cand_v >= (PTR_W+1)'(N_REQ)) begin
                cand_v = cand_v - (PTR_W+1)'(N_REQ);
            end else begin
                cand_v = cand_v;
            end
            if (!found_v && req_v[cand_v[PTR_W-1:0]]) begin
                found_v = 1'b1;
                idx_v   = cand_v[PTR_W-1:0];
            end else begin
                found_v = found_v;
            end
        end
        return {found_v, idx_v};
    endfunction

    function automatic logic [PTR_W-1:0] next_index(input logic [PTR_W-1:0] idx_v);
        logic [PTR_W-1:0] nxt_v;
        if (idx_v == PTR_W'(N_REQ - 1)) begin
            nxt_v = {PTR_W{1'b0}};
        end else begin
            nxt_v = idx_v + PTR_W'(1);
        end
        return nxt_v;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx_v);
        logic [N_REQ-1:0] one_v;
        one_v = {{(N_REQ-1){1'b0}}, 1'b1};
        return one_v << idx_v;
    endfunction

    state_t           state_r,    state_nxt_s;
    logic [PTR_W-1:0] ptr_r,      ptr_nxt_s;
    logic [PTR_W-1:0] owner_r,    owner_nxt_s;
    logic [7:0]       hold_cnt_r, hold_cnt_nxt_s;
    logic [N_REQ-1:0] gnt_r,      gnt_nxt_s;
    logic             busy_r,     busy_nxt_s;

    logic [PTR_W:0]   pick_s;
    logic             pick_found_s;
    logic [PTR_W-1:0] pick_idx_s;
    logic             owner_req_s;
    logic             timeout_s;

    assign pick_s       = rr_pick(bus.req, ptr_r);
    assign pick_found_s = pick_s[PTR_W];
    assign pick_idx_s   = pick_s[PTR_W-1:0];
    assign owner_req_s  = bus.req[owner_r];

`ifdef EN_ARB_TIMEOUT_EN
    assign timeout_s = (hold_cnt_r == HOLD_LIMIT);
`else
    logic unused_s;
    assign unused_s  = ^{HOLD_LIMIT};
    assign timeout_s = 1'b0;
`endif

    // Next-state and next-output decode; everything holds while ena is low.
    always_comb begin
        state_nxt_s    = state_r;
        ptr_nxt_s      = ptr_r;
        owner_nxt_s    = owner_r;
        hold_cnt_nxt_s = hold_cnt_r;
        gnt_nxt_s      = gnt_r;
        busy_nxt_s     = busy_r;
        if (bus.ena) begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        owner_nxt_s    = pick_idx_s;
                        gnt_nxt_s      = onehot(pick_idx_s);
                        busy_nxt_s     = 1'b1;
                        hold_cnt_nxt_s = 8'd1;
                        state_nxt_s    = ST_GRANT;
                    end else begin
                        gnt_nxt_s  = {N_REQ{1'b0}};
                        busy_nxt_s = 1'b0;
                    end
                end
                ST_GRANT: begin
                    // A forced release rotates exactly like a voluntary one.
                    if (!owner_req_s || timeout_s) begin
                        gnt_nxt_s   = {N_REQ{1'b0}};
                        busy_nxt_s  = 1'b0;
                        ptr_nxt_s   = next_index(owner_r);
                        state_nxt_s = ST_IDLE;
                    end else if (hold_cnt_r != 8'hFF) begin
                        hold_cnt_nxt_s = hold_cnt_r + 8'd1;
                    end else begin
                        hold_cnt_nxt_s = hold_cnt_r;
                    end
                end
                default: begin
                    gnt_nxt_s   = {N_REQ{1'b0}};
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {PTR_W{1'b0}};
            owner_r    <= {PTR_W{1'b0}};
            hold_cnt_r <= 8'd0;
            gnt_r      <= {N_REQ{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ptr_r      <= ptr_nxt_s;
            owner_r    <= owner_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            gnt_r      <= gnt_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign bus.gnt    = gnt_r;
    assign bus.busy   = busy_r;
    assign bus.en_out = |(gnt_r & bus.din);

endmodule

// File: tb/tb_en_arbiter.sv
// Directed-vector bench for en_arbiter (N_REQ=4, MAX_HOLD=3); the timeout
// expectations follow EN_ARB_TIMEOUT_EN exactly as the RTL build does.
module tb_en_arbiter;

    localparam int N = 4;
`ifdef EN_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    en_arbiter_if #(.N_REQ(N)) bus ();

    en_arbiter #(.N_REQ(N), .MAX_HOLD(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.ena = 1'b1;
        bus.req = 4'b0000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        bus.ena = 1'b1;
        bus.req = 4'b1111;
        bus.din = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            step();
            n_vec++;
            if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.en_out !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold[%0d]: gnt=%b busy=%b en_out=%b, want 0000/0/0",
                         c, bus.gnt, bus.busy, bus.en_out);
            end
        end
        rst = 1'b0;
        step();
        n_vec++;
        if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 || bus.en_out !== 1'b1) begin
            n_err++;
            $display("FAIL reset_first_grant: gnt=%b busy=%b en_out=%b, want 0001/1/1",
                     bus.gnt, bus.busy, bus.en_out);
        end
        bus.req = 4'b0000;
        step();
        n_vec++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: gnt=%b busy=%b, want 0000/0", bus.gnt, bus.busy);
        end
    endtask

    task automatic test_single();
        logic       d;
        logic       on;
        logic [3:0] exp_gnt;
        do_reset();
        bus.din = 4'b1011;
        bus.req = 4'b0100;
        step();
        // Granted cycle 1..5 with din[2] toggling; a timeout build idles in cycle 4.
        for (int cyc = 1; cyc <= 5; cyc++) begin
            d       = (cyc % 2 == 1);
            bus.din = {1'b1, d, 2'b11};
            #1;
            on      = !(TMO && cyc == 4);
            exp_gnt = on ? 4'b0100 : 4'b0000;
            n_vec++;
            if (bus.gnt !== exp_gnt || bus.en_out !== (on & d)) begin
                n_err++;
                $display("FAIL single_cyc%0d: gnt=%b en_out=%b, want %b/%b",
                         cyc, bus.gnt, bus.en_out, exp_gnt, on & d);
            end
            step();
        end
        n_vec++;
        if (bus.gnt !== 4'b0100 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_cyc6: gnt=%b busy=%b, want 0100/1", bus.gnt, bus.busy);
        end
        bus.req = 4'b0000;
        step();
        bus.din = 4'b1111;
        #1;
        n_vec++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.en_out !== 1'b0) begin
            n_err++;
            $display("FAIL single_release: gnt=%b busy=%b en_out=%b, want 0000/0/0",
                     bus.gnt, bus.busy, bus.en_out);
        end
    endtask

    task automatic test_rotation();
        int         seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_gnt;
        do_reset();
        bus.din = 4'b1111;
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << seq[k];
            for (int h = 0; h < 2; h++) begin
                step();
                n_vec++;
                if (bus.gnt !== exp_gnt || bus.busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL rotation_k%0d_h%0d: gnt=%b busy=%b, want %b/1",
                             k, h, bus.gnt, bus.busy, exp_gnt);
                end
            end
            bus.req[seq[k]] = 1'b0;
            step();
            n_vec++;
            if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL rotation_gap_k%0d: gnt=%b busy=%b, want 0000/0",
                         k, bus.gnt, bus.busy);
            end
            bus.req = 4'b1111;
        end
        bus.req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_wraparound();
        do_reset();
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        step();
        bus.req = 4'b0011;
        step();
        n_vec++;
        if (bus.gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL wraparound: gnt=%b, want 0001", bus.gnt);
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req = 4'b0001;
        step();
        n_vec++;
        if (bus.gnt !== 4'b0001) begin
            n_err++;
            $display("FAIL b2b_first: gnt=%b, want 0001", bus.gnt);
        end
        bus.req = 4'b0010;
        step();
        n_vec++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_gap: gnt=%b busy=%b, want 0000/0", bus.gnt, bus.busy);
        end
        step();
        n_vec++;
        if (bus.gnt !== 4'b0010 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second: gnt=%b busy=%b, want 0010/1", bus.gnt, bus.busy);
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_timeout();
        logic [3:0] tab [12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000,
                                 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        logic [3:0] exp_gnt;
        do_reset();
        bus.req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_gnt = TMO ? tab[i] : 4'b0001;
            n_vec++;
            if (bus.gnt !== exp_gnt || bus.busy !== (|exp_gnt)) begin
                n_err++;
                $display("FAIL timeout_cyc%0d: gnt=%b busy=%b, want %b/%b",
                         i, bus.gnt, bus.busy, exp_gnt, |exp_gnt);
            end
        end
        bus.req = 4'b0000;
        step();
        step();
    endtask

    task automatic test_ena();
        logic d;
        do_reset();
        bus.din = 4'b1111;
        bus.req = 4'b0001;
        step();
        bus.ena = 1'b0;
        bus.req = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            d       = (i % 2 == 0);
            bus.din = {3'b111, d};
            step();
            n_vec++;
            if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1 || bus.en_out !== d) begin
                n_err++;
                $display("FAIL ena_hold%0d: gnt=%b busy=%b en_out=%b, want 0001/1/%b",
                         i, bus.gnt, bus.busy, bus.en_out, d);
            end
        end
        bus.ena = 1'b1;
        step();
        n_vec++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL ena_release: gnt=%b busy=%b, want 0000/0", bus.gnt, bus.busy);
        end
        bus.ena = 1'b0;
        bus.req = 4'b0100;
        step();
        n_vec++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL ena_idle_hold: gnt=%b busy=%b, want 0000/0", bus.gnt, bus.busy);
        end
        bus.ena = 1'b1;
        step();
        n_vec++;
        if (bus.gnt !== 4'b0100) begin
            n_err++;
            $display("FAIL ena_idle_grant: gnt=%b, want 0100", bus.gnt);
        end
        bus.req = 4'b0000;
        step();
    endtask

    initial begin
        rst     = 1'b1;
        bus.ena = 1'b1;
        bus.req = 4'b0000;
        bus.din = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_wraparound();
        test_back_to_back();
        test_timeout();
        test_ena();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
